// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width; a width of 1 still suffices for the WIDTH=2 corner.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring shift-subtract step of an unsigned division.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle by the owning FSM.
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit in, subtract if it fits, otherwise restore.
  // The compare uses the full shifted value, so the modular subtraction
  // below only matters when the true difference is non-negative.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    trial   = shifted[WIDTH:0] - {1'b0, divisor};
    rem_out = q_bit ? trial : shifted[WIDTH:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned divider: quotient/remainder via one restoring step per clock.
// Latency: WIDTH+1 cycles start-to-done (1 cycle for a zero divisor).
// Backpressure: start is ignored while busy; accepted in IDLE or in the done cycle.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state, next_state;
  logic             accept;
  logic             last_step;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] dq_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dq_r[WIDTH-1]),
    .divisor (dvs_r),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and handshake outputs; DONE accepts start like IDLE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    busy       = (state == CALC);
    done       = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (divisor == '0) ? DONE : CALC;
        end else if (state == DONE) begin
          next_state = IDLE;
        end
      end
      CALC: begin
        if (count == '0) begin
          last_step  = 1'b1;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-subtract iteration, result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem_r       <= '0;
      dq_r        <= '0;
      dvs_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dq_r  <= dividend;
      dvs_r <= divisor;
      rem_r <= '0;
      count <= LAST_CNT;
      // A zero divisor skips the iteration and reports immediately.
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      rem_r <= rem_next;
      dq_r  <= {dq_r[WIDTH-2:0], q_bit};
      if (count != '0) count <= count - 1'b1;
      if (last_step) begin
        quotient    <= {dq_r[WIDTH-2:0], q_bit};
        remainder   <= rem_next[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  restoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         acc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   pushed   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (busy) begin
        failures++;
        $display("FAIL busy_done_overlap actual=1 required=0");
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done q=%0d r=%0d required=no_done", quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        check8("quotient", quotient, e.q);
        check8("remainder", remainder, e.r);
        check8("div_by_zero", {7'd0, div_by_zero}, {7'd0, e.z});
        checks++;
        if (cyc - e.acc + 1 != e.lat) begin
          failures++;
          $display("FAIL latency actual=%0d required=%0d", cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  // Issue one division once the divider can take it; optionally score it.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez,
                        input bit push, output bit done_at_issue);
    int guard = 0;
    @(posedge clk); #1;
    while (busy && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=busy required=idle");
    end
    done_at_issue = done;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      exp_q.push_back('{q: eq, r: er, z: ez, acc: cyc, lat: (b == 8'd0) ? 1 : 9});
      pushed++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[9] = '{
    '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0},
    '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0},
    '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0},
    '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0},
    '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0},
    '{8'd1,   8'd1,   8'd1,   8'd0,   1'b0},
    '{8'd99,  8'd10,  8'd9,   8'd9,   1'b0},
    '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1},
    '{8'd250, 8'd25,  8'd10,  8'd0,   1'b0}
  };

  initial begin
    bit dai;
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check8("reset_busy", {7'd0, busy}, 8'd0);
    check8("reset_done", {7'd0, done}, 8'd0);
    check8("reset_quotient", quotient, 8'd0);
    check8("reset_remainder", remainder, 8'd0);
    check8("reset_dbz", {7'd0, div_by_zero}, 8'd0);
    @(negedge clk) rst_n = 1'b1;

    // Basic division.
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1, dai);
    repeat (12) @(posedge clk);

    // Back-to-back: second start lands in the first done cycle.
    run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1, dai);
    run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b1, dai);
    check8("b2b_no_idle", {7'd0, dai}, 8'd1);
    repeat (12) @(posedge clk);

    // Divide by zero, then a normal division clears the flag.
    run_op(8'd37, 8'd0, 8'd255, 8'd37, 1'b1, 1'b1, dai);
    check8("dbz_busy_low", {7'd0, busy}, 8'd0);
    @(posedge clk); #1;
    check8("dbz_busy_low_next", {7'd0, busy}, 8'd0);
    run_op(8'd37, 8'd5, 8'd7, 8'd2, 1'b0, 1'b1, dai);
    repeat (12) @(posedge clk);

    // Start pulsed mid-calculation must be ignored.
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1, dai);
    repeat (2) @(posedge clk);
    #1;
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check8("ignored_start_hold_q", quotient, 8'd14);
    check8("ignored_start_hold_r", remainder, 8'd2);

    // Asynchronous reset in the middle of a calculation.
    run_op(8'd200, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0, dai);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check8("midreset_busy", {7'd0, busy}, 8'd0);
    check8("midreset_done", {7'd0, done}, 8'd0);
    check8("midreset_quotient", quotient, 8'd0);
    check8("midreset_remainder", remainder, 8'd0);
    check8("midreset_dbz", {7'd0, div_by_zero}, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b1, dai);

    // Directed edge cases, issued back-to-back.
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b1, dai);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    checks++;
    if (done_cnt != pushed) begin
      failures++;
      $display("FAIL done_count actual=%0d required=%0d", done_cnt, pushed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
